// File: rtl/uart_recv2.sv
// Two-byte UART receiver: 16x oversampled 8N1 frames are collected in pairs.
// A pair is published on data1/data0 with a one-cycle valid. A bad stop bit or a missing second byte aborts the pair with a flag pulse.
module uart_recv2 #(
  parameter int GAP_MAX = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in,
  output logic [7:0] data1,
  output logic [7:0] data0,
  output logic       valid,
  output logic       sgn,
  output logic       frame_err,
  output logic       timeout
);

  localparam int GW = $clog2(GAP_MAX + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT} state_t;

  state_t          state;
  logic            sync1, rx_s;
  logic [3:0]      cnt;
  logic [2:0]      bit_idx;
  logic            byte_idx;
  logic [7:0]      shreg;
  logic [7:0]      held;
  logic [GW-1:0]   gap;

  // Both synchronizer flops reset high so a fresh falling edge is needed after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= in;
      rx_s  <= sync1;
    end
  end

  // NOTE: every state register uses non-blocking assignment so all branches see pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      byte_idx  <= 1'b0;
      shreg     <= '0;
      held      <= '0;
      gap       <= '0;
      data1     <= '0;
      data0     <= '0;
      valid     <= 1'b0;
      sgn       <= 1'b0;
      frame_err <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      timeout   <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state    <= START;
            cnt      <= '0;
            byte_idx <= 1'b0;
            sgn      <= 1'b1;
          end
        end
        START: begin
          if (cnt == 4'd7) begin
            if (rx_s) begin
              state <= IDLE;
              sgn   <= 1'b0;
            end else begin
              state   <= DATA;
              cnt     <= '0;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DATA: begin
          // cnt wraps 15 -> 0 on its own, which also gives STOP a clean start.
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            if (!rx_s) begin
              frame_err <= 1'b1;
              state     <= IDLE;
              sgn       <= 1'b0;
            end else if (!byte_idx) begin
              held  <= shreg;
              gap   <= '0;
              state <= WAIT;
            end else begin
              data1 <= held;
              data0 <= shreg;
              valid <= 1'b1;
              state <= IDLE;
              sgn   <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (!rx_s) begin
            state    <= START;
            cnt      <= '0;
            byte_idx <= 1'b1;
          end else if (gap == GW'(GAP_MAX - 1)) begin
            timeout <= 1'b1;
            held    <= '0;
            state   <= IDLE;
            sgn     <= 1'b0;
          end else begin
            gap <= gap + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          sgn   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_recv2.sv
// Directed bench for uart_recv2: pairs, glitch, frame error, timeout, reset abort.
module tb_uart_recv2;

  logic       clk = 1'b0;
  logic       rst;
  logic       in;
  logic [7:0] data1, data0;
  logic       valid, sgn, frame_err, timeout;

  uart_recv2 #(.GAP_MAX(64)) dut (
    .clk(clk), .rst(rst), .in(in),
    .data1(data1), .data0(data0),
    .valid(valid), .sgn(sgn), .frame_err(frame_err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts events, remembers when they happened.
  int   n_valid = 0, n_ferr = 0, n_tmo = 0;
  int   t_valid = -1, t_ferr = -1, t_tmo = -1;
  int   wide_err = 0, excl_err = 0;
  logic prev_valid = 1'b0, prev_ferr = 1'b0, prev_tmo = 1'b0;
  logic sgn_after_valid = 1'b1;

  always @(negedge clk) begin
    if (prev_valid) sgn_after_valid = sgn;
    if (valid) begin n_valid++; t_valid = cyc; end
    if (frame_err) begin n_ferr++; t_ferr = cyc; end
    if (timeout) begin n_tmo++; t_tmo = cyc; end
    if ((valid && prev_valid) || (frame_err && prev_ferr) || (timeout && prev_tmo)) wide_err++;
    if ((32'(valid) + 32'(frame_err) + 32'(timeout)) > 1) excl_err++;
    prev_valid = valid;
    prev_ferr  = frame_err;
    prev_tmo   = timeout;
  end

  int n_cmp = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one 8N1 frame at 16 clk/bit starting at the current negedge.
  task automatic send_byte(input logic [7:0] b, input logic stop, output int t0);
    t0 = cyc;
    in = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      in = b[i];
      tick(16);
    end
    in = stop;
    tick(16);
    in = 1'b1;
  endtask

  int t1, t2;
  logic [7:0] p1 [3] = '{8'h11, 8'h33, 8'h5A};
  logic [7:0] p0 [3] = '{8'h22, 8'h44, 8'hC3};

  initial begin
    rst = 1'b0;
    in  = 1'b1;
    tick(3);
    check("rst_data1", 32'(data1), 32'h0);
    check("rst_data0", 32'(data0), 32'h0);
    check("rst_flags", {28'h0, valid, sgn, frame_err, timeout}, 32'h0);
    rst = 1'b1;
    tick(5);

    // Back-to-back pair; rx_s low is seen by the FSM 3 edges after drive, valid 152 later.
    send_byte(8'hA5, 1'b1, t1);
    send_byte(8'h3C, 1'b1, t2);
    tick(5);
    check("pair_data1", 32'(data1), 32'hA5);
    check("pair_data0", 32'(data0), 32'h3C);
    check("pair_nvalid", n_valid, 1);
    check("pair_latency", t_valid, t2 + 155);
    check("pair_sgn_after", 32'(sgn_after_valid), 32'h0);
    check("pair_noflags", n_ferr + n_tmo, 0);

    // Short low glitch in IDLE.
    in = 1'b0;
    tick(4);
    in = 1'b1;
    tick(1);
    check("glitch_sgn_hi", 32'(sgn), 32'h1);
    tick(20);
    check("glitch_sgn_lo", 32'(sgn), 32'h0);
    check("glitch_counts", {n_valid[7:0], n_ferr[7:0], n_tmo[7:0]}, 32'h010000);
    check("glitch_data", {data1, data0}, 32'hA53C);

    // Second byte with a bad stop bit.
    send_byte(8'h55, 1'b1, t1);
    send_byte(8'hFF, 1'b0, t2);
    tick(40);
    check("ferr_count", n_ferr, 1);
    check("ferr_latency", t_ferr, t2 + 155);
    check("ferr_novalid", n_valid, 1);
    check("ferr_data", {data1, data0}, 32'hA53C);

    // Lone byte, then silence: timeout 64 clk after WAIT entry.
    send_byte(8'h81, 1'b1, t1);
    tick(300);
    check("tmo_count", n_tmo, 1);
    check("tmo_latency", t_tmo, t1 + 155 + 64);
    check("tmo_novalid", n_valid, 1);
    check("tmo_sgn", 32'(sgn), 32'h0);

    // Reset during DATA of the second byte.
    send_byte(8'h12, 1'b1, t1);
    in = 1'b0;
    tick(40);
    rst = 1'b0;
    tick(1);
    check("mrst_data", {data1, data0}, 32'h0);
    check("mrst_flags", {28'h0, valid, sgn, frame_err, timeout}, 32'h0);
    in = 1'b1;
    tick(5);
    rst = 1'b1;
    tick(20);
    check("mrst_noflag", {n_valid[7:0], n_ferr[7:0], n_tmo[7:0]}, 32'h010101);
    send_byte(8'h00, 1'b1, t1);
    send_byte(8'hFF, 1'b1, t2);
    tick(5);
    check("mrst_pair", {data1, data0}, 32'h00FF);
    check("mrst_nvalid", n_valid, 2);
    check("mrst_latency", t_valid, t2 + 155);

    // Three pairs separated by one idle bit.
    for (int k = 0; k < 3; k++) begin
      send_byte(p1[k], 1'b1, t1);
      send_byte(p0[k], 1'b1, t2);
      tick(5);
      check($sformatf("multi%0d_data", k), {data1, data0}, {16'h0, p1[k], p0[k]});
      check($sformatf("multi%0d_latency", k), t_valid, t2 + 155);
      tick(11);
    end
    check("multi_nvalid", n_valid, 5);
    check("multi_noflags", {n_ferr[7:0], n_tmo[7:0]}, 32'h0101);
    check("pulse_width", wide_err, 0);
    check("pulse_exclusive", excl_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
